// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: LC-3b word/cacheline types and the
// arbiter FSM state encoding.
package mem_arbiter_pkg;

   localparam int unsigned LC3B_WORD_W = 16;
   localparam int unsigned LC3B_LINE_W = 128;

   typedef logic [LC3B_WORD_W-1:0] lc3b_word;
   typedef logic [LC3B_LINE_W-1:0] lc3b_cacheline;

   typedef enum logic [2:0] {
      IDLE,
      SERVE_I,
      SERVE_D,
      RESP_I,
      RESP_D
   } mem_arbiter_state_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of D grants made while the I-cache was waiting.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   inc             : a D grant happened while I was requesting
//   clr             : an I grant happened
//   at_limit_c      : count has reached STARVE_LIMIT (combinational from count)
// Only instantiated when MEM_ARBITER_STARVE_GUARD_EN is defined.
module arb_starve_counter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic clr,
   output logic at_limit_c
);

   localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

   logic [CNT_W-1:0] count;

   // Saturates at STARVE_LIMIT; an I grant always wins over an increment.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != CNT_W'(STARVE_LIMIT))) begin
         count <= count + CNT_W'(1);
      end
   end

   assign at_limit_c = (count == CNT_W'(STARVE_LIMIT));

endmodule

// File: rtl/mem_arbiter.sv
// Serializes I-cache line fills, D-cache line fills and D-cache writebacks
// onto the single physical memory port. A granted request is latched and held
// on the memory port until pmem_resp, then a one-cycle registered response is
// returned to the winning cache. D has priority over I.
// Optional: MEM_ARBITER_STARVE_GUARD_EN lets I win after STARVE_LIMIT
// consecutive D grants made while I was waiting.
// Ports:
//   clk, rst_n                    : clock, synchronous active-low reset
//   icache_pmem_read/address      : I-cache fill request
//   icache_pmem_rdata/resp        : I-cache fill data and completion pulse
//   dcache_pmem_read/write/address/wdata : D-cache fill / writeback request
//   dcache_pmem_rdata/resp        : D-cache fill data and completion pulse
//   pmem_read/write/address/wdata : physical memory request (registered)
//   pmem_rdata/resp               : physical memory response
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W       = 16,
   parameter int unsigned LINE_W       = 128,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              icache_pmem_read,
   input  logic [ADDR_W-1:0] icache_pmem_address,
   output logic [LINE_W-1:0] icache_pmem_rdata,
   output logic              icache_pmem_resp,
   input  logic              dcache_pmem_read,
   input  logic              dcache_pmem_write,
   input  logic [ADDR_W-1:0] dcache_pmem_address,
   input  logic [LINE_W-1:0] dcache_pmem_wdata,
   output logic [LINE_W-1:0] dcache_pmem_rdata,
   output logic              dcache_pmem_resp,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_address,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp
);

   mem_arbiter_state_t state;

   logic d_req_c;
   logic i_pri_c;
   logic d_grant_c;
   logic i_grant_c;

   assign d_req_c   = dcache_pmem_read | dcache_pmem_write;
   assign d_grant_c = (state == IDLE) && d_req_c && !i_pri_c;
   assign i_grant_c = (state == IDLE) && icache_pmem_read && !d_grant_c;

`ifdef MEM_ARBITER_STARVE_GUARD_EN
   logic starved_c;

   arb_starve_counter #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clk        (clk),
      .rst_n      (rst_n),
      .inc        (d_grant_c & icache_pmem_read),
      .clr        (i_grant_c),
      .at_limit_c (starved_c)
   );

   // I overrides D only once it has been passed over STARVE_LIMIT times.
   assign i_pri_c = starved_c & icache_pmem_read;
`else
   // Strict D-over-I priority; STARVE_LIMIT has no effect in this build.
   assign i_pri_c = 1'b0 & (STARVE_LIMIT != 0);
`endif

   // FSM, request latch (the pmem_* registers) and response registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state             <= IDLE;
         pmem_read         <= 1'b0;
         pmem_write        <= 1'b0;
         pmem_address      <= '0;
         pmem_wdata        <= '0;
         icache_pmem_rdata <= '0;
         icache_pmem_resp  <= 1'b0;
         dcache_pmem_rdata <= '0;
         dcache_pmem_resp  <= 1'b0;
      end else begin
         icache_pmem_resp <= 1'b0;
         dcache_pmem_resp <= 1'b0;
         case (state)
            IDLE: begin
               if (d_grant_c) begin
                  // Read and write together is treated as a write.
                  pmem_write   <= dcache_pmem_write;
                  pmem_read    <= ~dcache_pmem_write;
                  pmem_address <= dcache_pmem_address;
                  pmem_wdata   <= dcache_pmem_wdata;
                  state        <= SERVE_D;
               end else if (i_grant_c) begin
                  pmem_read    <= 1'b1;
                  pmem_write   <= 1'b0;
                  pmem_address <= icache_pmem_address;
                  pmem_wdata   <= '0;
                  state        <= SERVE_I;
               end
            end
            SERVE_I: begin
               if (pmem_resp) begin
                  icache_pmem_rdata <= pmem_rdata;
                  icache_pmem_resp  <= 1'b1;
                  pmem_read         <= 1'b0;
                  pmem_write        <= 1'b0;
                  state             <= RESP_I;
               end
            end
            SERVE_D: begin
               if (pmem_resp) begin
                  dcache_pmem_rdata <= pmem_rdata;
                  dcache_pmem_resp  <= 1'b1;
                  pmem_read         <= 1'b0;
                  pmem_write        <= 1'b0;
                  state             <= RESP_D;
               end
            end
            RESP_I, RESP_D: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic, checked against a transaction-level arbitration model.
module tb_mem_arbiter;

   localparam int unsigned ADDR_W       = 16;
   localparam int unsigned LINE_W       = 128;
   localparam int unsigned STARVE_LIMIT = 4;
`ifdef MEM_ARBITER_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic              clk;
   logic              rst_n;
   logic              icache_pmem_read;
   logic [ADDR_W-1:0] icache_pmem_address;
   logic [LINE_W-1:0] icache_pmem_rdata;
   logic              icache_pmem_resp;
   logic              dcache_pmem_read;
   logic              dcache_pmem_write;
   logic [ADDR_W-1:0] dcache_pmem_address;
   logic [LINE_W-1:0] dcache_pmem_wdata;
   logic [LINE_W-1:0] dcache_pmem_rdata;
   logic              dcache_pmem_resp;
   logic              pmem_read;
   logic              pmem_write;
   logic [ADDR_W-1:0] pmem_address;
   logic [LINE_W-1:0] pmem_wdata;
   logic [LINE_W-1:0] pmem_rdata;
   logic              pmem_resp;

   mem_arbiter #(
      .ADDR_W       (ADDR_W),
      .LINE_W       (LINE_W),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .icache_pmem_read    (icache_pmem_read),
      .icache_pmem_address (icache_pmem_address),
      .icache_pmem_rdata   (icache_pmem_rdata),
      .icache_pmem_resp    (icache_pmem_resp),
      .dcache_pmem_read    (dcache_pmem_read),
      .dcache_pmem_write   (dcache_pmem_write),
      .dcache_pmem_address (dcache_pmem_address),
      .dcache_pmem_wdata   (dcache_pmem_wdata),
      .dcache_pmem_rdata   (dcache_pmem_rdata),
      .dcache_pmem_resp    (dcache_pmem_resp),
      .pmem_read           (pmem_read),
      .pmem_write          (pmem_write),
      .pmem_address        (pmem_address),
      .pmem_wdata          (pmem_wdata),
      .pmem_rdata          (pmem_rdata),
      .pmem_resp           (pmem_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state: D grants passed over a waiting I, last rdata per cache.
   int unsigned       starve_cnt = 0;
   logic [LINE_W-1:0] m_i_rdata  = '0;
   logic [LINE_W-1:0] m_d_rdata  = '0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_l(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_a(input string tag, input logic [ADDR_W-1:0] obs, input logic [ADDR_W-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_b(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   function automatic logic [LINE_W-1:0] rand_line();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Arbitration rule: 0 = no grant, 1 = I, 2 = D.
   function automatic int pick(input logic i_req, input logic d_req);
      if (d_req && !(GUARD && i_req && (starve_cnt >= STARVE_LIMIT))) return 2;
      if (i_req) return 1;
      return 0;
   endfunction

   task automatic all_zero(input string tag);
      chk_b({tag, "_pmem_read"},  pmem_read,  1'b0);
      chk_b({tag, "_pmem_write"}, pmem_write, 1'b0);
      chk_a({tag, "_pmem_addr"},  pmem_address, '0);
      chk_l({tag, "_pmem_wdata"}, pmem_wdata, '0);
      chk_b({tag, "_i_resp"},     icache_pmem_resp, 1'b0);
      chk_b({tag, "_d_resp"},     dcache_pmem_resp, 1'b0);
      chk_l({tag, "_i_rdata"},    icache_pmem_rdata, '0);
      chk_l({tag, "_d_rdata"},    dcache_pmem_rdata, '0);
   endtask

   // Requester-side disturbance while a transaction is in flight.
   task automatic perturb(input int mode);
      if (mode == 1) begin
         icache_pmem_read    = 1'($urandom_range(0, 1));
         dcache_pmem_read    = 1'($urandom_range(0, 1));
         dcache_pmem_write   = 1'($urandom_range(0, 1));
         icache_pmem_address = ADDR_W'($urandom());
         dcache_pmem_address = ADDR_W'($urandom());
         dcache_pmem_wdata   = rand_line();
      end else if (mode == 2) begin
         dcache_pmem_address = 16'hFFFF;
      end
   endtask

   // Arbitrate on the currently driven requests and, if granted, run one
   // memory transaction with 'lat' wait cycles returning 'data'.
   task automatic run_txn(input int lat, input logic [LINE_W-1:0] data, input int mode);
      logic              i_req;
      logic              d_wr;
      logic              exp_wr;
      logic [ADDR_W-1:0] exp_addr;
      logic [LINE_W-1:0] exp_wdata;
      int                who;
      i_req     = icache_pmem_read;
      d_wr      = dcache_pmem_write;
      who       = pick(i_req, dcache_pmem_read | dcache_pmem_write);
      exp_wr    = (who == 2) && d_wr;
      exp_addr  = (who == 2) ? dcache_pmem_address : icache_pmem_address;
      exp_wdata = dcache_pmem_wdata;
      pmem_resp = 1'($urandom_range(0, 1));   // must be ignored in IDLE
      tick();
      pmem_resp = 1'b0;
      if (who == 0) begin
         chk_b("idle_pmem_read",  pmem_read,  1'b0);
         chk_b("idle_pmem_write", pmem_write, 1'b0);
         return;
      end
      if (who == 2 && i_req && starve_cnt < STARVE_LIMIT) starve_cnt++;
      if (who == 1) starve_cnt = 0;
      chk_b("grant_read",  pmem_read,  !exp_wr);
      chk_b("grant_write", pmem_write, exp_wr);
      chk_a("grant_addr",  pmem_address, exp_addr);
      if (exp_wr) chk_l("grant_wdata", pmem_wdata, exp_wdata);
      for (int k = 0; k < lat; k++) begin
         perturb(mode);
         tick();
         chk_a("stable_addr",  pmem_address, exp_addr);
         chk_b("stable_read",  pmem_read,  !exp_wr);
         chk_b("stable_write", pmem_write, exp_wr);
         if (exp_wr) chk_l("stable_wdata", pmem_wdata, exp_wdata);
         chk_b("early_i_resp", icache_pmem_resp, 1'b0);
         chk_b("early_d_resp", dcache_pmem_resp, 1'b0);
      end
      perturb(mode);
      pmem_resp  = 1'b1;
      pmem_rdata = data;
      tick();
      pmem_resp  = 1'b0;
      pmem_rdata = rand_line();
      if (who == 1) m_i_rdata = data;
      else          m_d_rdata = data;
      chk_b("resp_pmem_read",  pmem_read,  1'b0);
      chk_b("resp_pmem_write", pmem_write, 1'b0);
      chk_b("resp_i_pulse", icache_pmem_resp, who == 1);
      chk_b("resp_d_pulse", dcache_pmem_resp, who == 2);
      chk_l("resp_i_rdata", icache_pmem_rdata, m_i_rdata);
      chk_l("resp_d_rdata", dcache_pmem_rdata, m_d_rdata);
      perturb(mode);                           // requests ignored in RESP
      tick();
      chk_b("post_i_resp", icache_pmem_resp, 1'b0);
      chk_b("post_d_resp", dcache_pmem_resp, 1'b0);
      chk_b("post_pmem_read",  pmem_read,  1'b0);
      chk_b("post_pmem_write", pmem_write, 1'b0);
   endtask

   task automatic clear_reqs();
      icache_pmem_read  = 1'b0;
      dcache_pmem_read  = 1'b0;
      dcache_pmem_write = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n      = 1'b1;
      starve_cnt = 0;
      m_i_rdata  = '0;
      m_d_rdata  = '0;
   endtask

   initial begin
      logic [ADDR_W-1:0] exp_g;

      // Reset held two cycles with both caches requesting.
      rst_n               = 1'b0;
      icache_pmem_read    = 1'b1;
      icache_pmem_address = 16'h0100;
      dcache_pmem_read    = 1'b1;
      dcache_pmem_write   = 1'b0;
      dcache_pmem_address = 16'h0200;
      dcache_pmem_wdata   = '0;
      pmem_rdata          = '0;
      pmem_resp           = 1'b0;
      tick();
      all_zero("rst_c1");
      tick();
      all_zero("rst_c2");
      rst_n = 1'b1;
      starve_cnt = 0;
      run_txn(1, rand_line(), 0);              // D read granted 1 cycle after release
      clear_reqs();

      // Lone I read.
      icache_pmem_read    = 1'b1;
      icache_pmem_address = 16'h1230;
      run_txn(3, 128'h0123456789ABCDEF0123456789ABCDEF, 0);
      clear_reqs();

      // Simultaneous I read and D write; D address changes mid-serve.
      icache_pmem_read    = 1'b1;
      icache_pmem_address = 16'h0040;
      dcache_pmem_write   = 1'b1;
      dcache_pmem_address = 16'h8000;
      dcache_pmem_wdata   = {32{4'hA}};
      run_txn(2, 128'h11112222333344445555666677778888, 2);
      chk_a("simul_first_addr", pmem_address, 16'h8000);
      dcache_pmem_write = 1'b0;
      run_txn(1, 128'h99990000AAAABBBBCCCCDDDDEEEEFFFF, 0);
      chk_a("simul_second_addr", pmem_address, 16'h0040);
      clear_reqs();

      // Reset during SERVE_I drops the transaction.
      icache_pmem_read    = 1'b1;
      icache_pmem_address = 16'h2222;
      tick();
      chk_b("rstmid_grant", pmem_read, 1'b1);
      tick();
      rst_n     = 1'b0;
      pmem_resp = 1'b1;
      tick();
      chk_b("rstmid_pmem_read", pmem_read, 1'b0);
      chk_b("rstmid_i_resp", icache_pmem_resp, 1'b0);
      chk_l("rstmid_i_rdata", icache_pmem_rdata, '0);
      rst_n      = 1'b1;
      pmem_resp  = 1'b0;
      starve_cnt = 0;
      m_i_rdata  = '0;
      m_d_rdata  = '0;
      clear_reqs();
      tick();
      chk_b("rstmid_after_read", pmem_read, 1'b0);
      chk_b("rstmid_after_resp", icache_pmem_resp, 1'b0);
      dcache_pmem_read    = 1'b1;
      dcache_pmem_address = 16'h3330;
      run_txn(0, rand_line(), 0);
      clear_reqs();

      // Continuous D and I requests: grant order.
      do_reset();
      icache_pmem_read    = 1'b1;
      icache_pmem_address = 16'h0100;
      dcache_pmem_read    = 1'b1;
      dcache_pmem_address = 16'h0200;
      for (int g = 0; g < 6; g++) begin
         run_txn(1, rand_line(), 0);
         exp_g = (GUARD && g == 4) ? 16'h0100 : 16'h0200;
         chk_a("starve_order", pmem_address, exp_g);
      end
      clear_reqs();

      // Random traffic against the model.
      for (int n = 0; n < 60; n++) begin
         perturb(1);
         if ($urandom_range(0, 3) == 0) clear_reqs();
         run_txn(int'($urandom_range(0, 3)), rand_line(), 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the I-cache and D-cache miss ports, which serve the pipeline's instruction and data memory interfaces.
- Serializes cacheline reads (I and D) and D-cache writebacks onto the single physical memory port.
- Latches each granted request, holds it stable on the memory port until the memory responds, then returns a registered response to the winning cache.

Parameters:
- ADDR_W, 16, address width (lc3b_word).
- LINE_W, 128, cacheline width in bits.
- STARVE_LIMIT, 4, consecutive D grants tolerated while I waits (only used with the optional feature).

Ports:
- clk in 1: system clock.
- rst_n in 1: reset.
- icache_pmem_read in 1: I-cache line-fill request.
- icache_pmem_address in ADDR_W: I-cache line address.
- icache_pmem_rdata out LINE_W: fill data to I-cache.
- icache_pmem_resp out 1: one-cycle completion pulse to I-cache.
- dcache_pmem_read in 1: D-cache line-fill request.
- dcache_pmem_write in 1: D-cache writeback request.
- dcache_pmem_address in ADDR_W: D-cache line address.
- dcache_pmem_wdata in LINE_W: writeback data.
- dcache_pmem_rdata out LINE_W: fill data to D-cache.
- dcache_pmem_resp out 1: one-cycle completion pulse to D-cache.
- pmem_read out 1: physical memory read.
- pmem_write out 1: physical memory write.
- pmem_address out ADDR_W: physical memory address.
- pmem_wdata out LINE_W: physical memory write data.
- pmem_rdata in LINE_W: physical memory read data.
- pmem_resp in 1: physical memory completion.

Interface rule (already decided): one clock, clk; reset rst_n is synchronous and active-low. Every flop clears on a rising clk edge where rst_n==0.

Behaviour:
- States: IDLE, SERVE_I, SERVE_D, RESP_I, RESP_D. Reset state is IDLE.
- Reset values: all outputs 0, including rdata registers. Latched request registers are cleared.
- IDLE:
  - Grants when a request is seen at the clock edge.
  - D request (read or write) wins over I when both are asserted in the same cycle.
  - On grant, latch address, wdata and operation, then enter SERVE_x.
  - pmem_resp in IDLE is ignored.
- SERVE_x:
  - pmem_read/pmem_write/pmem_address/pmem_wdata are driven only from the latched registers.
  - They stay stable until pmem_resp, regardless of requester inputs.
  - On pmem_resp: capture pmem_rdata into the winner's rdata register and enter RESP_x.
  - pmem_read/write drop to 0 the cycle after pmem_resp.
- RESP_x:
  - x_pmem_resp=1 for exactly one cycle, with rdata valid.
  - Always goes to IDLE next; requests are ignored in this state.
- Latency:
  - Request seen at edge t -> pmem_read/pmem_write high in cycle t+1.
  - pmem_resp at edge u -> resp pulse in cycle u+1 -> IDLE at u+2.
  - Minimum turnaround is 3 cycles plus memory latency.
- dcache_pmem_read and dcache_pmem_write both high: treated as a write (read ignored).
- A requester deasserting mid-transaction does not abort it; the transaction completes and resp still pulses.
- rdata outputs hold their last captured value between responses. The non-winning cache's rdata is untouched.
- rst_n low mid-SERVE: next cycle returns to IDLE, pmem_read/pmem_write go to 0, and the pending transaction is dropped with no resp.
- No combinational path from any input to any output.

Optional Feature:
- Macro: MEM_ARBITER_STARVE_GUARD_EN.
- With the macro:
  - A saturating counter (width $clog2(STARVE_LIMIT+1)) increments on each D grant made while icache_pmem_read is high.
  - When the count equals STARVE_LIMIT and I is requesting, I wins the next IDLE arbitration even if D requests.
  - The counter clears on any I grant and on reset.
- Without the macro: strict D-over-I priority and no counter logic.

Decomposition:
- lc3b_types gains:
  - lc3b_cacheline (logic [127:0]).
  - mem_arbiter_state_t enum with the five states.
- Sub-module arb_starve_counter, instantiated only under MEM_ARBITER_STARVE_GUARD_EN.
- FSM, request latch and response registers stay in mem_arbiter.

Test Plan:
- Reset:
  - Stimulus: hold rst_n=0 for 2 cycles with both caches requesting.
  - Required: all outputs 0 throughout; first pmem_read exactly 1 cycle after rst_n rises.
- Lone I read:
  - Stimulus: icache_pmem_read, address 0x1230; memory responds 3 cycles later with 0x0123..CDEF.
  - Required: pmem_address=0x1230; icache_pmem_resp pulses once, one cycle after pmem_resp, with that data; dcache_pmem_resp stays 0.
- Simultaneous requests:
  - Stimulus: I read 0x0040 and D write 0x8000 (wdata 0xAAAA...) asserted together.
  - Required: write to 0x8000 served first; I read served next; two resp pulses, D then I.
- Stable latched request:
  - Stimulus: D changes address to 0xFFFF during SERVE_D.
  - Required: pmem_address stays at the original 0x8000 until pmem_resp.
- Reset mid-transaction:
  - Stimulus: rst_n=0 during SERVE_I.
  - Required: pmem_read=0 next cycle; no icache_pmem_resp; IDLE afterwards.
- Starvation guard:
  - Stimulus: continuous D and I requests (macro on, STARVE_LIMIT=4).
  - Required: grant order D,D,D,D,I,D... With the macro off: D only while D keeps requesting.
